// File: rtl/bcd_scan_display_if.sv
// Reader-side bus of the BCD counter: packed digits plus load strobe in, segment/digit drive out.
interface bcd_scan_display_if #(
  parameter int unsigned NDIG = 4
);
  logic [4*NDIG-1:0] bcd_in;
  logic              load;
  logic [6:0]        seg_out;
  logic [NDIG-1:0]   dig_sel;
  logic              err;

  modport master (output bcd_in, load, input seg_out, dig_sel, err);
  modport slave  (input bcd_in, load, output seg_out, dig_sel, err);
endinterface

// File: rtl/bcd_scan_display.sv
// Multiplexed 7-segment scanner for an NDIG-digit packed BCD word with a blank gap between digits.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZ_BLANK_EN.
module bcd_scan_display #(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic              stepclk,
  input  logic              reset,
  bcd_scan_display_if.slave bus
);

  localparam int unsigned IdxW  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CntW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NDIG - 1);
  localparam logic [CntW-1:0] PcntLast = CntW'(SCAN_DIV - 1);

  typedef enum logic {StBlank, StShow} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     pcnt_q, pcnt_d;
  logic [4*NDIG-1:0]   shadow_q, shadow_d;
  logic                err_q, err_d;
  logic                bad_in;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pcnt_d   = pcnt_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    unique case (state_q)
      StBlank: begin
        state_d = StShow;
        pcnt_d  = '0;
      end
      StShow: begin
        if (pcnt_q == PcntLast) begin
          state_d = StBlank;
          pcnt_d  = '0;
          idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: state_d = StBlank;
    endcase
    // Capture is independent of the scan, so a load on a slot edge feeds the new digit directly.
    if (bus.load) begin
      shadow_d = bus.bcd_in;
      err_d    = bad_in;
    end
  end

  always_ff @(posedge stepclk or negedge reset) begin
    if (!reset) begin
      state_q  <= StBlank;
      idx_q    <= '0;
      pcnt_q   <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pcnt_q   <= pcnt_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  logic [3:0]      cur_nib;
  logic [6:0]      seg;
  logic [NDIG-1:0] dig;
`ifdef BCD_SCAN_LZ_BLANK_EN
  logic            zeros_above;
  logic            lz_blank;
`endif

  always_comb begin
    cur_nib = '0;
`ifdef BCD_SCAN_LZ_BLANK_EN
    zeros_above = 1'b1;
    lz_blank    = 1'b0;
`endif
    // Walk from the most significant digit so the leading-zero run is known at each position.
    for (int i = NDIG - 1; i >= 0; i--) begin
`ifdef BCD_SCAN_LZ_BLANK_EN
      zeros_above = zeros_above & (shadow_q[4*i +: 4] == 4'd0);
`endif
      if (idx_q == IdxW'(i)) begin
        cur_nib = shadow_q[4*i +: 4];
`ifdef BCD_SCAN_LZ_BLANK_EN
        lz_blank = zeros_above && (i > 0);
`endif
      end
    end
    seg = '0;
    dig = '0;
    if (state_q == StShow) begin
      dig = NDIG'(1) << idx_q;
      seg = seg_decode(cur_nib);
`ifdef BCD_SCAN_LZ_BLANK_EN
      if (lz_blank) seg = '0;
`endif
    end
  end

  assign bus.seg_out = seg;
  assign bus.dig_sel = dig;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized bench for bcd_scan_display against a frame-position arithmetic model.
module tb_bcd_scan_display;

  localparam int NDIG = 4;
  localparam int SD   = 4;
  localparam int SLOT = SD + 1;
  localparam int FRM  = NDIG * SLOT;

  logic stepclk = 1'b0;
  logic reset   = 1'b0;

  bcd_scan_display_if #(.NDIG(NDIG)) bus ();

  bcd_scan_display #(.NDIG(NDIG), .SCAN_DIV(SD)) dut (
    .stepclk (stepclk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 stepclk = ~stepclk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b1;

  // Model: edges since reset release, and captured word/error flag.
  int          k_m      = 0;
  logic [15:0] shadow_m = '0;
  logic        err_m    = 1'b0;
  logic [6:0]  seg_tbl [16];

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  end

  always @(posedge stepclk or negedge reset) begin
    if (!reset) begin
      k_m      = 0;
      shadow_m = '0;
      err_m    = 1'b0;
    end else begin
      k_m = k_m + 1;
      if (bus.load) begin
        shadow_m = bus.bcd_in;
        err_m    = 1'b0;
        for (int i = 0; i < NDIG; i++) if (((bus.bcd_in >> (4*i)) & 16'hF) > 9) err_m = 1'b1;
      end
    end
  end

  function automatic void model_out(output logic [6:0] s, output logic [3:0] d);
    int p;
    int dg;
    logic [15:0] upper;
    s = '0;
    d = '0;
    if (k_m > 0) begin
      p  = (k_m - 1) % FRM;
      dg = p / SLOT;
      if ((p % SLOT) < SD) begin
        upper = shadow_m >> (4*dg);
        d = 4'(1 << dg);
        s = seg_tbl[upper[3:0]];
`ifdef BCD_SCAN_LZ_BLANK_EN
        if (dg > 0 && upper == 16'h0) s = '0;
`endif
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge stepclk) begin
    logic [6:0] s;
    logic [3:0] d;
    if (chk_en) begin
      model_out(s, d);
      check("model seg_out", 32'(bus.seg_out), 32'(s));
      check("model dig_sel", 32'(bus.dig_sel), 32'(d));
      check("model err", 32'(bus.err), 32'(err_m));
    end
  end

  // Advance to the negedge where digit dg has just been lit (first SHOW cycle).
  task automatic wait_slot(input int dg);
    bit found = 1'b0;
    for (int n = 0; n < 4 * FRM && !found; n++) begin
      @(negedge stepclk);
      if (k_m > 0 && ((k_m - 1) % FRM) == dg * SLOT) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_slot %0d: digit never lit, expected within %0d cycles", dg, 4 * FRM);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.bcd_in = v;
    bus.load   = 1'b1;
    @(negedge stepclk);
    bus.load   = 1'b0;
  endtask

  initial begin
    bus.bcd_in = '0;
    bus.load   = 1'b0;
    // Reset held three cycles.
    repeat (3) @(negedge stepclk);
    check("reset seg", 32'(bus.seg_out), 32'h00);
    check("reset dig", 32'(bus.dig_sel), 32'h0);
    check("reset err", 32'(bus.err), 32'h0);
    reset = 1'b1;
    @(negedge stepclk);
    check("edge1 dig", 32'(bus.dig_sel), 32'h1);
    check("edge1 seg", 32'(bus.seg_out), 32'h3F);
    repeat (3) @(negedge stepclk);
    check("edge4 dig", 32'(bus.dig_sel), 32'h1);
    @(negedge stepclk);
    check("edge5 blank", 32'(bus.dig_sel), 32'h0);
    @(negedge stepclk);
    check("edge6 dig", 32'(bus.dig_sel), 32'h2);

    // Valid word over a full frame.
    do_load(16'h1234);
    wait_slot(0); check("1234 d0", 32'(bus.seg_out), 32'h66);
    wait_slot(1); check("1234 d1", 32'(bus.seg_out), 32'h4F);
    wait_slot(2); check("1234 d2", 32'(bus.seg_out), 32'h5B);
    wait_slot(3); check("1234 d3", 32'(bus.seg_out), 32'h06);
    check("1234 err", 32'(bus.err), 32'h0);

    // Invalid nibble sets err; a clean load clears it.
    do_load(16'h12A4);
    check("12A4 err", 32'(bus.err), 32'h1);
    wait_slot(1); check("12A4 dash", 32'(bus.seg_out), 32'h40);
    do_load(16'h0009);
    check("0009 err", 32'(bus.err), 32'h0);

    // Leading zeros.
    do_load(16'h0042);
    wait_slot(3);
    check("0042 d3 dig", 32'(bus.dig_sel), 32'h8);
`ifdef BCD_SCAN_LZ_BLANK_EN
    check("0042 d3 seg", 32'(bus.seg_out), 32'h00);
`else
    check("0042 d3 seg", 32'(bus.seg_out), 32'h3F);
`endif
    wait_slot(1); check("0042 d1", 32'(bus.seg_out), 32'h66);
    wait_slot(0); check("0042 d0", 32'(bus.seg_out), 32'h5B);
    do_load(16'h0000);
    wait_slot(0); check("0000 d0", 32'(bus.seg_out), 32'h3F);

    // Mid-slot reload.
    do_load(16'h5555);
    wait_slot(0);
    repeat (2) @(negedge stepclk);
    check("5555 d0 pcnt2", 32'(bus.seg_out), 32'h6D);
    do_load(16'h5557);
    check("5557 d0 switch", 32'(bus.seg_out), 32'h07);
    check("5557 d0 still lit", 32'(bus.dig_sel), 32'h1);
    @(negedge stepclk);
    check("5557 slot end", 32'(bus.dig_sel), 32'h0);

    // Randomized loads, including held-high load and invalid nibbles.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] v;
      for (int i = 0; i < NDIG; i++) begin
        logic [3:0] nb;
        nb = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
        if (i >= 2 && $urandom_range(0, 2) == 0) nb = 4'd0;
        v[4*i +: 4] = nb;
      end
      bus.bcd_in = v;
      bus.load   = ($urandom_range(0, 3) == 0);
      @(negedge stepclk);
    end
    bus.load = 1'b0;

    // Asynchronous reset mid-slot of digit 2.
    do_load(16'h9876);
    wait_slot(2);
    #2 reset = 1'b0;
    #1;
    check("async rst seg", 32'(bus.seg_out), 32'h00);
    check("async rst dig", 32'(bus.dig_sel), 32'h0);
    @(negedge stepclk);
    reset = 1'b1;
    @(negedge stepclk);
    check("post rst dig", 32'(bus.dig_sel), 32'h1);
    check("post rst seg", 32'(bus.seg_out), 32'h3F);
    repeat (FRM) @(negedge stepclk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Multiplexed 7-segment display driver for the BCD counter output. It is the reader side of the counter's `cnt_out` bus.
- Captures an NDIG-digit packed BCD word on a load strobe into a shadow register.
- Scans the digits one at a time with a blanking gap between digits to suppress ghosting.
- Decodes each digit to segments and flags invalid (non-BCD) nibbles.

Parameters:
- NDIG, 4, number of BCD digits/display positions (1..8); digit 0 = least significant.
- SCAN_DIV, 4, number of clock cycles each digit is lit per scan slot (>=1).

Ports:
- stepclk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset, 1 = run).
- bcd_in  input  4*NDIG  packed BCD word; nibble i = bcd_in[4*i+3:4*i].
- load  input  1  capture strobe; sampled on stepclk rising edge.
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active-high.
- dig_sel  output  NDIG  one-hot digit enable, active-high; all-zero while blanking.
- err  output  1  high while any shadow nibble > 9.

Behaviour:
- Registers: shadow[4*NDIG-1:0], state {BLANK, SHOW}, idx (digit index), pcnt (slot counter, 0..SCAN_DIV-1), err.
- Reset (reset=0, asynchronous, holds while low):
  - shadow=0, state=BLANK, idx=0, pcnt=0, err=0.
  - Therefore seg_out=7'h00 and dig_sel=0.
- Outputs are combinational from registers only; there is no combinational path from bcd_in or load to the outputs.
- BLANK state:
  - dig_sel=0, seg_out=0.
  - Next edge: state=SHOW, pcnt=0; idx unchanged.
- SHOW state:
  - dig_sel=1<<idx; seg_out=decode(shadow nibble idx).
  - Edge with pcnt==SCAN_DIV-1: state=BLANK, idx=(idx==NDIG-1)?0:idx+1, pcnt=0.
  - Otherwise: pcnt=pcnt+1.
- Timing:
  - Each digit slot = 1 BLANK cycle + SCAN_DIV SHOW cycles. Frame = NDIG*(SCAN_DIV+1) cycles.
  - Digit 0 is first lit on the 1st edge after reset deasserts.
- Load:
  - On an edge with load=1: shadow<=bcd_in, and err<=(any nibble of bcd_in > 9).
  - Visible on seg_out the cycle after that edge if the addressed digit is in SHOW. Load mid-SHOW therefore changes segments mid-slot; this is allowed.
  - load does not disturb state, idx, or pcnt.
  - load held high recaptures on every edge.
- Decode (hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble A..F: dash 7'h40.
- err is updated only on load. It clears on a load containing all-valid digits.
- Load coincident with slot advance: both take effect on the same edge. The new idx displays new shadow data.
- Reset asserted mid-scan: immediate return to reset values. Scan restarts at digit 0 after release.

Optional Feature:
- Macro: BCD_SCAN_LZ_BLANK_EN (leading-zero blanking).
- Defined: while in SHOW, digit i>0 outputs seg_out=0 when shadow nibbles NDIG-1 down to i are all 0.
  - dig_sel and timing are unchanged.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Invalid nibbles count as non-zero.
- Undefined: all digits are always decoded (leading zeros shown as 3F).

Test Plan (NDIG=4, SCAN_DIV=4):
1. Reset low 3 cycles, then high, no load -> during reset seg_out=00, dig_sel=0000, err=0. Edges 1-4 after release: dig_sel=0001, seg_out=3F. Edge 5: dig_sel=0000. Edges 6-9: dig_sel=0010. Pattern repeats every 20 cycles.
2. load=1 one cycle with bcd_in=16'h1234 -> over a frame: dig_sel 0001/seg 66, 0010/4F, 0100/5B, 1000/06, each lit 4 cycles with a 1-cycle blank between; err=0.
3. load 16'h12A4 -> err=1 the cycle after load; digit 1 shows 40. Then load 16'h0009 -> err=0.
4. load 16'h0042 with BCD_SCAN_LZ_BLANK_EN -> digits 3,2 show seg_out=00 with dig_sel still 1000/0100; digits 1,0 show 66/5B. Without the macro, digits 3,2 show 3F. load 16'h0000 with the macro -> only digit 0 shows 3F.
5. load 16'h5555 then, mid-SHOW of digit 0 (pcnt=2), load 16'h5557 -> seg_out changes 6D->07 the next cycle. pcnt/idx progression is unaltered and the slot still ends after 4 lit cycles.
6. Reset pulsed low during digit 2 SHOW -> outputs go 00/0000 asynchronously. After release, digit 0 is lit at the 1st edge; shadow reads 0000 (seg 3F).
